// File: rtl/sup1_pkg.sv
// Shared SUP-1 display definitions: segment codes, display FSM encoding and
// the BCD / digit-formatting helpers used by the output stage.
package sup1_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned BIN_W  = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned ITER_W = 3;
    localparam int unsigned NDIG   = 4;

    // Active-low, ordered {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } disp_state_e;

    // Index 0 = ones digit, index 3 = sign digit
    typedef logic [NDIG-1:0][SEG_W-1:0] digits_t;

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [SEG_W-1:0] digit_seg(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

    // Leading-zero blanking; the ones digit is always shown
    function automatic digits_t format_digits(input logic [BCD_W-1:0] bcd,
                                              input logic             neg);
        digits_t d;
        logic [3:0] hun;
        logic [3:0] ten;
        hun  = bcd[11:8];
        ten  = bcd[7:4];
        d[0] = digit_seg(bcd[3:0]);
        d[1] = (hun == 4'd0 && ten == 4'd0) ? SEG_BLANK : digit_seg(ten);
        d[2] = (hun == 4'd0) ? SEG_BLANK : digit_seg(hun);
        d[3] = neg ? SEG_MINUS : SEG_BLANK;
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one iteration per clock, eight iterations per
// conversion. A start pulse always restarts from scratch.
module bin2bcd_seq
    import sup1_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0]  shreg;
    logic [ITER_W-1:0] cnt;
    logic              active;
    logic [BCD_W+BIN_W-1:0] step_c;

    // Adjust then shift the combined {bcd, binary} scratch left by one
    always_comb begin
        step_c = {bcd_adjust(bcd), shreg};
        step_c = step_c << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            bcd    <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            shreg  <= bin;
            bcd    <= '0;
            cnt    <= '0;
            active <= 1'b1;
            done   <= 1'b0;
        end else if (active) begin
            bcd   <= step_c[BCD_W+BIN_W-1:BIN_W];
            shreg <= step_c[BIN_W-1:0];
            cnt   <= cnt + ITER_W'(1);
            if (cnt == ITER_W'(BIN_W - 1)) begin
                active <= 1'b0;
                done   <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/output_display.sv
// SUP-1 output stage: latches the bus on oi, converts to decimal and drives a
// 4-digit multiplexed active-low 7-segment display.
module output_display
    import sup1_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned DATA_W      = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus,
    input  logic              oi,
    input  logic              signed_mode,
    output logic [DATA_W-1:0] value,
    output logic              busy,
    output logic [SEG_W-1:0]  seg,
    output logic [NDIG-1:0]   an
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SEL_W = 2;

    disp_state_e       state;
    logic              neg;
    logic [ITER_W-1:0] iter;

    logic [CNT_W-1:0]  rcnt;
    logic [SEL_W-1:0]  sel;
    digits_t           dig;

    logic              neg_c;
    logic [DATA_W-1:0] mag_c;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;

    logic              wrap_c;
    logic              commit_c;
    logic [CNT_W-1:0]  rcnt_next_c;
    logic [SEL_W-1:0]  sel_next_c;
    digits_t           dig_next_c;

    // Magnitude of the bus byte; 0x80 in signed mode wraps to 128
    always_comb begin
        neg_c = signed_mode & bus[DATA_W-1];
        mag_c = neg_c ? DATA_W'(~bus + DATA_W'(1)) : bus;
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (oi),
        .bin   (mag_c),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Load / convert / commit sequencing; a new oi always restarts
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            value <= '0;
            neg   <= 1'b0;
            iter  <= '0;
            busy  <= 1'b0;
        end else if (oi) begin
            state <= CONV;
            value <= bus;
            neg   <= neg_c;
            iter  <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CONV: begin
                    iter <= iter + ITER_W'(1);
                    if (iter == ITER_W'(BIN_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Next refresh position and digit contents; seg/an follow them in step
    always_comb begin
        wrap_c      = (rcnt == CNT_W'(REFRESH_DIV - 1));
        rcnt_next_c = wrap_c ? '0 : rcnt + CNT_W'(1);
        sel_next_c  = wrap_c ? sel + SEL_W'(1) : sel;
        commit_c    = (state == DONE) && conv_done && !oi;
        dig_next_c  = commit_c ? format_digits(conv_bcd, neg) : dig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            sel  <= '0;
            dig  <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_DIGIT[0]};
            an   <= 4'b1110;
            seg  <= SEG_DIGIT[0];
        end else begin
            rcnt <= rcnt_next_c;
            sel  <= sel_next_c;
            dig  <= dig_next_c;
            an   <= ~(NDIG'(1) << sel_next_c);
            seg  <= dig_next_c[sel_next_c];
        end
    end

endmodule

// File: doc/output_display.md
Name: output_display

Overview:
- Output stage of SUP-1, directly downstream of the shared bus.
- When the control unit asserts oi, the block latches the bus byte into the output register.
- It then converts the byte to decimal with a sequential double-dabble and drives a 4-digit multiplexed 7-segment display.
- The display shows unsigned (0..255) or two's-complement signed (-128..127) values with leading-zero blanking.

Parameters:
- REFRESH_DIV, 1000: clk cycles each digit stays selected before the mux advances; legal range 2..65535.
- DATA_W, 8: bus width. Fixed at 8; the BCD width and iteration count are derived from it.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bus  in  8  shared data bus.
- oi  in  1  output-register load strobe from the control unit.
- signed_mode  in  1  1 = display the value as two's complement; sampled only when oi loads.
- value  out  8  current output-register contents.
- busy  out  1  high while a conversion is in progress (state != IDLE).
- seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- an  out  4  active-low digit enables, one-hot; an[0] = ones digit, an[3] = sign digit.

Behaviour:
- Reset values: value=0; state=IDLE; busy=0; refresh counter=0; sel=0; an=4'b1110.
- Reset display digits = {blank, blank, blank, 0}, so seg=7'b1000000 immediately after reset.
- Segment codes: blank=7'b1111111, '-'=7'b0111111, digits 0-9 use the standard gfedcba active-low table.
- Load (edge E0, oi=1):
  - value<=bus; neg<=signed_mode & bus[7].
  - mag<=neg ? (~bus+1) : bus, truncated to 8 bits (0x80 gives 128).
  - BCD scratch cleared; iter<=0; state<=CONV.
- CONV (edges E1..E8):
  - One double-dabble iteration per edge: add 3 to every BCD nibble >=5, then shift left one bit, bringing in the mag MSB.
  - After the 8th iteration, state<=DONE.
- DONE (edge E9):
  - Digit registers update atomically; state<=IDLE.
  - busy is high from after E0 through E9; the display changes at E9.
  - Load-to-display latency is exactly 9 cycles.
- Digit formatting, applied at commit:
  - d0 = ones, always shown.
  - d1 = tens, blank if hundreds=0 and tens=0.
  - d2 = hundreds, blank if 0.
  - d3 = '-' if neg, else blank.
- oi while busy: the new value is loaded, the conversion restarts from E0, and the old conversion is discarded without any partial commit.
- oi held for multiple cycles: it reloads every cycle, so the display commits 9 cycles after the last oi cycle.
- rst during CONV/DONE: aborts; all state returns to reset values.
- rst and oi in the same cycle: rst wins.
- Refresh:
  - The counter increments every cycle.
  - On reaching REFRESH_DIV-1 it wraps to 0 and sel<=sel+1 (mod 4).
  - an = ~(1<<sel); seg = code of digit[sel].
  - Refresh runs independently of conversion; the displayed digits keep their old values until commit.
- seg and an are registered, so they lag sel by zero cycles relative to the registered sel (both are driven from registered state with no extra pipeline stage).

Decomposition:
- Shared package sup1_pkg holds:
  - SEG_BLANK, SEG_MINUS and the SEG_DIGIT[0:9] table.
  - Display-FSM state encoding (IDLE=2'd0, CONV=2'd1, DONE=2'd2).
- One sub-module, bin2bcd_seq: sequential double-dabble.
  - Ports: clk, rst, start, bin[7:0], done, bcd[11:0].
  - output_display owns the FSM, output register, formatting and refresh mux.

Test Plan:
- Reset 3 cycles -> value=0, busy=0, an=1110, seg=1000000; digits 1..3 show 1111111 as the mux sweeps.
- REFRESH_DIV=4, no load -> an sequence 1110, 1101, 1011, 0111, 1110, each step held 4 cycles.
- bus=0xFF, oi=1 for 1 cycle, signed_mode=0 -> busy high 9 cycles; digits then {blank,2,5,5}.
- bus=0x80, signed_mode=1 -> digits {-,1,2,8}; bus=0xFB, signed_mode=1 -> {-,blank,blank,5}.
- bus=0x07, then bus=0x64 with oi 4 cycles later -> 0x07 is never committed; {blank,1,0,0} appears 9 cycles after the second oi.
- bus=0x2A load, rst asserted at E5 -> value=0, busy=0, digits {blank,blank,blank,0}; oi+rst in the same cycle -> reset state.
